// File: rtl/i2s_mic_array_rx_if.sv
// Frame stream from the microphone-array receiver towards the DMA side.
// The receiver drives data/valid through the master modport; the consumer returns ready.
interface i2s_mic_array_rx_if #(
  parameter int unsigned DATA_W = 128
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/i2s_mic_array_rx.sv
// Multi-line I2S receiver for the microphone array.
// Captures one stereo frame per data line using a shared BCLK/LRCLK and buffers
// whole frames in a FIFO. It also exposes the last complete L/R pair of one
// selected line to the codec playback path.
module i2s_mic_array_rx #(
  parameter int unsigned NUM_MICS   = 4,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IRQ_LEVEL  = 8,
  localparam int unsigned SEL_W     = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1,
  localparam int unsigned FILL_W    = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned FRAME_W   = 2 * NUM_MICS * SAMPLE_W
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic [NUM_MICS-1:0]   GPIO_DIN,
  input  logic                  enable,
  input  logic [NUM_MICS-1:0]   mic_mask,
  input  logic [SEL_W-1:0]      codec_sel,
  i2s_mic_array_rx_if.master    out_if,
  output logic [31:0]           codec_stream,
  output logic [FILL_W-1:0]     fill_level,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic                  sync_err,
  input  logic                  sync_err_clr,
  output logic                  irq
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_W);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_PAD   = 2'd3;

  // Synchronisers; bclk_q[2] is the registered copy used for edge detection
  logic [2:0]          bclk_q;
  logic [1:0]          lr_q;
  logic [NUM_MICS-1:0] din_s1_q, din_s2_q;
  logic                bclk_rise, lr_s, lr_last_q, lr_fall, lr_rise;
  logic [NUM_MICS-1:0] din_s;

  // Frame FSM and shift registers
  logic [1:0]          state_q, state_d;
  logic                chan_q, chan_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] sh_l_q [NUM_MICS];
  logic [SAMPLE_W-1:0] sh_l_d [NUM_MICS];
  logic [SAMPLE_W-1:0] sh_r_q [NUM_MICS];
  logic [SAMPLE_W-1:0] sh_r_d [NUM_MICS];
  logic                done_set, serr_set;
  logic [FRAME_W-1:0]  frame_d, frame_q;
  logic                frame_done_q;

  // FIFO and status
  logic [FRAME_W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]   count_q;
  logic                full, push, pop, ovf_set;
  logic                overflow_q, sync_err_q, irq_q;
  logic [31:0]         codec_q;
  logic [SAMPLE_W-1:0] codec_l, codec_r;
  int unsigned         sel;

  assign bclk_rise = bclk_q[1] & ~bclk_q[2];
  assign lr_s      = lr_q[1];
  assign din_s     = din_s2_q;
  assign lr_fall   = lr_last_q & ~lr_s;
  assign lr_rise   = ~lr_last_q & lr_s;

  // 2-FF synchronisers for all pins, plus the LRCLK level seen at the previous BCLK rise
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bclk_q    <= '0;
      lr_q      <= '0;
      din_s1_q  <= '0;
      din_s2_q  <= '0;
      lr_last_q <= 1'b0;
    end else begin
      bclk_q   <= {bclk_q[1:0], AUD_BCLK};
      lr_q     <= {lr_q[0], AUD_ADCLRCK};
      din_s1_q <= GPIO_DIN;
      din_s2_q <= din_s1_q;
      if (bclk_rise) lr_last_q <= lr_s;
    end
  end

  // Frame FSM next state. The I2S offset bit is the one on which the LRCLK edge
  // is observed, so the first rise handled in DELAY already carries the MSB;
  // cnt then tracks the index of the bit being shifted (1..SAMPLE_W-1) in SHIFT.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    cnt_d    = cnt_q;
    sh_l_d   = sh_l_q;
    sh_r_d   = sh_r_q;
    done_set = 1'b0;
    serr_set = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else if (bclk_rise) begin
      case (state_q)
        S_IDLE: begin
          if (lr_fall) begin
            state_d = S_DELAY;
            chan_d  = 1'b0;
          end
        end
        S_DELAY, S_SHIFT: begin
          if (lr_fall || lr_rise) begin
            serr_set = 1'b1;
            chan_d   = 1'b0;
            state_d  = lr_fall ? S_DELAY : S_IDLE;
          end else begin
            for (int unsigned k = 0; k < NUM_MICS; k++) begin
              if (chan_q) sh_r_d[k] = {sh_r_q[k][SAMPLE_W-2:0], din_s[k]};
              else        sh_l_d[k] = {sh_l_q[k][SAMPLE_W-2:0], din_s[k]};
            end
            if (state_q == S_DELAY) begin
              state_d = S_SHIFT;
              cnt_d   = CNT_W'(1);
            end else if (cnt_q == CNT_W'(SAMPLE_W - 1)) begin
              state_d  = S_PAD;
              done_set = chan_q;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_PAD: begin
          if (lr_fall) begin
            state_d = S_DELAY;
            chan_d  = 1'b0;
          end else if (lr_rise) begin
            state_d = S_DELAY;
            chan_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Assemble the completed frame; the right words include the bit captured this cycle
  always_comb begin
    frame_d = '0;
    for (int unsigned k = 0; k < NUM_MICS; k++) begin
      if (mic_mask[k]) begin
        frame_d[(2*k+1)*SAMPLE_W +: SAMPLE_W] = sh_l_q[k];
        frame_d[(2*k)*SAMPLE_W   +: SAMPLE_W] = sh_r_d[k];
      end
    end
  end

  // FSM, shift registers and completed-frame holding register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      chan_q       <= 1'b0;
      cnt_q        <= '0;
      sh_l_q       <= '{default: '0};
      sh_r_q       <= '{default: '0};
      frame_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      cnt_q        <= cnt_d;
      sh_l_q       <= sh_l_d;
      sh_r_q       <= sh_r_d;
      frame_done_q <= done_set;
      if (done_set) frame_q <= frame_d;
    end
  end

  // FIFO control: a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    full    = (count_q == FILL_W'(FIFO_DEPTH));
    pop     = (count_q != '0) && out_if.out_ready;
    push    = frame_done_q && (!full || pop);
    ovf_set = frame_done_q && full && !pop;
  end

  // Codec line selection; out-of-range selects fall back to line 0
  always_comb begin
    sel = 0;
    if (32'(codec_sel) < NUM_MICS) sel = 32'(codec_sel);
    codec_l = frame_q[(2*sel+1)*SAMPLE_W +: SAMPLE_W];
    codec_r = frame_q[(2*sel)*SAMPLE_W   +: SAMPLE_W];
  end

  // Left-justify a sample into 16 bits: top bits if wider, zero-filled if narrower
  function automatic logic [15:0] to16(input logic [SAMPLE_W-1:0] s);
    logic [47:0] w;
    w = '0;
    w[47 -: SAMPLE_W] = s;
    return w[47:32];
  endfunction

  // FIFO storage, pointers, fill count, sticky flags, irq and codec latch
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
      irq_q      <= 1'b0;
      codec_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= frame_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      overflow_q <= ovf_set  | (overflow_q & ~overflow_clr);
      sync_err_q <= serr_set | (sync_err_q & ~sync_err_clr);
      irq_q      <= (count_q >= FILL_W'(IRQ_LEVEL));
      if (frame_done_q) codec_q <= {to16(codec_l), to16(codec_r)};
    end
  end

  assign out_if.out_data  = mem_q[rd_ptr_q];
  assign out_if.out_valid = (count_q != '0);
  assign fill_level       = count_q;
  assign overflow         = overflow_q;
  assign sync_err         = sync_err_q;
  assign irq              = irq_q;
  assign codec_stream     = codec_q;

endmodule

// File: tb/tb_i2s_mic_array_rx.sv
// Self-checking bench for i2s_mic_array_rx: drives standard I2S frames
// (LRCLK changes on BCLK fall, MSB one bit after the change, 32-bit slots)
// and compares against a frame-level queue model.
module tb_i2s_mic_array_rx;
  localparam int NM   = 4;
  localparam int SW   = 16;
  localparam int FD   = 16;
  localparam int IRQL = 8;
  localparam int FW   = 2 * NM * SW;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          AUD_BCLK = 1'b0;
  logic          AUD_ADCLRCK = 1'b1;
  logic [NM-1:0] GPIO_DIN = '0;
  logic          enable = 1'b0;
  logic [NM-1:0] mic_mask = '1;
  logic [1:0]    codec_sel = 2'd2;
  logic [31:0]   codec_stream;
  logic [4:0]    fill_level;
  logic          overflow, sync_err, irq;
  logic          overflow_clr = 1'b0;
  logic          sync_err_clr = 1'b0;

  i2s_mic_array_rx_if #(.DATA_W(FW)) out_if ();

  i2s_mic_array_rx #(
    .NUM_MICS(NM), .SAMPLE_W(SW), .FIFO_DEPTH(FD), .IRQ_LEVEL(IRQL)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK),
    .GPIO_DIN(GPIO_DIN), .enable(enable), .mic_mask(mic_mask), .codec_sel(codec_sel),
    .out_if(out_if), .codec_stream(codec_stream), .fill_level(fill_level),
    .overflow(overflow), .overflow_clr(overflow_clr), .sync_err(sync_err),
    .sync_err_clr(sync_err_clr), .irq(irq)
  );

  always #10 CLK = ~CLK;

  int          tests = 0;
  int          fails = 0;
  logic [FW-1:0] q[$];
  logic [31:0] exp_codec = '0;
  logic        exp_ovf = 1'b0;
  logic        exp_serr = 1'b0;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_fill"},  FW'(fill_level), FW'(q.size()));
    check({tag, "_valid"}, FW'(out_if.out_valid), FW'(q.size() != 0));
    if (q.size() != 0) check({tag, "_head"}, out_if.out_data, q[0]);
    check({tag, "_irq"},   FW'(irq), FW'(q.size() >= IRQL));
    check({tag, "_codec"}, FW'(codec_stream), FW'(exp_codec));
    check({tag, "_ovf"},   FW'(overflow), FW'(exp_ovf));
    check({tag, "_serr"},  FW'(sync_err), FW'(exp_serr));
  endtask

  // One BCLK period: data/LRCLK change with the falling edge, then the rising edge.
  // With pop_here set, out_ready is pulsed for the CLK edge on which the push of
  // the frame whose last bit is on this rise lands (3 cycles sync + 1 cycle).
  task automatic send_bit(input logic lr, input logic [NM-1:0] d, input bit pop_here);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    GPIO_DIN    = d;
    repeat (8) @(negedge CLK);
    AUD_BCLK = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (pop_here && i == 2) begin
        check("simul_pop_head", out_if.out_data, q[0]);
        out_if.out_ready = 1'b1;
      end
      if (pop_here && i == 3) out_if.out_ready = 1'b0;
    end
  endtask

  task automatic send_channel(input logic lr, input logic [NM-1:0][SW-1:0] s,
                              input int nbits, input bit pop_last);
    logic [NM-1:0] d;
    for (int b = 0; b < nbits; b++) begin
      d = NM'($urandom);
      if (b >= 1 && b <= SW)
        for (int k = 0; k < NM; k++) d[k] = s[k][SW-b];
      send_bit(lr, d, pop_last && (b == SW));
    end
  endtask

  function automatic logic [FW-1:0] mk_frame(input logic [NM-1:0][SW-1:0] l,
                                             input logic [NM-1:0][SW-1:0] r,
                                             input logic [NM-1:0] m);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NM; k++)
      if (m[k]) begin
        f[(2*k+1)*SW +: SW] = l[k];
        f[(2*k)*SW   +: SW] = r[k];
      end
    return f;
  endfunction

  task automatic send_frame(input logic [NM-1:0][SW-1:0] l, input logic [NM-1:0][SW-1:0] r,
                            input bit pop_last);
    send_channel(1'b0, l, 32, 1'b0);
    send_channel(1'b1, r, 32, pop_last);
    exp_codec = mic_mask[codec_sel] ? {l[codec_sel], r[codec_sel]} : 32'h0;
    if (pop_last) begin
      void'(q.pop_front());
      q.push_back(mk_frame(l, r, mic_mask));
    end else if (q.size() < FD) begin
      q.push_back(mk_frame(l, r, mic_mask));
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic rand_frame(input bit pop_last);
    logic [NM-1:0][SW-1:0] l, r;
    for (int k = 0; k < NM; k++) begin
      l[k] = SW'($urandom);
      r[k] = SW'($urandom);
    end
    send_frame(l, r, pop_last);
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check({tag, "_pop_valid"}, FW'(out_if.out_valid), FW'(1));
      check({tag, "_pop_data"}, out_if.out_data, q[0]);
      out_if.out_ready = 1'b1;
      @(negedge CLK);
      out_if.out_ready = 1'b0;
      void'(q.pop_front());
    end
    repeat (2) @(negedge CLK);
    check_state(tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NM-1:0][SW-1:0] l, r;
    out_if.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check_state("reset");
    check("reset_data", out_if.out_data, '0);
    RESET_N = 1'b1;
    enable  = 1'b1;

    // Basic capture with fixed pattern, then random frames
    repeat (4) send_bit(1'b1, '0, 1'b0);
    for (int k = 0; k < NM; k++) begin
      l[k] = 16'hA000 + SW'(k);
      r[k] = 16'h5000 + SW'(k);
    end
    send_frame(l, r, 1'b0);
    check_state("basic0");
    check("basic_codec_const", FW'(codec_stream), FW'(32'hA0025002));
    for (int i = 0; i < 2; i++) begin
      rand_frame(1'b0);
      check_state("basic");
    end
    drain("basic_drain", 3);

    // Mask
    mic_mask = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      rand_frame(1'b0);
      check_state("mask");
    end
    drain("mask_drain", 2);
    mic_mask = 4'hF;

    // Backpressure and overflow
    for (int i = 0; i < 18; i++) begin
      rand_frame(1'b0);
      check_state("ovf_fill");
    end
    check("ovf_flag", FW'(overflow), FW'(1));
    @(negedge CLK) overflow_clr = 1'b1;
    @(negedge CLK) overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_clr", FW'(overflow), FW'(0));

    // Full FIFO: pop coincides with push
    rand_frame(1'b1);
    check_state("simul");
    drain("full_drain", 16);

    // Short slot: LRCLK toggles after 10 data bits of the left channel
    for (int k = 0; k < NM; k++) begin
      l[k] = SW'($urandom);
      r[k] = SW'($urandom);
    end
    send_channel(1'b0, l, 11, 1'b0);
    send_channel(1'b1, r, 32, 1'b0);
    exp_serr = 1'b1;
    check_state("short");
    rand_frame(1'b0);
    check_state("after_short");
    @(negedge CLK) sync_err_clr = 1'b1;
    @(negedge CLK) sync_err_clr = 1'b0;
    exp_serr = 1'b0;
    check("serr_clr", FW'(sync_err), FW'(0));
    drain("short_drain", 1);

    // Mid-left disable: partial frame discarded
    send_channel(1'b0, l, 8, 1'b0);
    enable = 1'b0;
    send_channel(1'b0, l, 24, 1'b0);
    enable = 1'b1;
    send_channel(1'b1, r, 32, 1'b0);
    check_state("disable");
    rand_frame(1'b0);
    check_state("after_disable");

    // Asynchronous reset mid-right
    send_channel(1'b0, l, 32, 1'b0);
    send_channel(1'b1, r, 8, 1'b0);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    q.delete();
    exp_codec = '0;
    check_state("async_reset");
    check("async_reset_data", out_if.out_data, '0);
    @(negedge CLK) RESET_N = 1'b1;
    send_channel(1'b1, r, 24, 1'b0);
    rand_frame(1'b0);
    check_state("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
